// File: rtl/fabric_config_pkg.sv
// Shared constants and types for the fabric configuration loader: stream
// marker words, address-word field positions and the loader state encoding.
package fabric_config_pkg;

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

    localparam int COL_MSB = 31;
    localparam int COL_LSB = 24;
    localparam int FRM_MSB = 23;
    localparam int FRM_LSB = 19;

    localparam int COL_W = COL_MSB - COL_LSB + 1;
    localparam int FRM_W = FRM_MSB - FRM_LSB + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_SKIP = 2'd3
    } state_t;

    // True when an address word names a frame that exists in the fabric.
    function automatic logic addr_in_range(input logic [31:0] word,
                                           input int num_cols,
                                           input int frames_per_col);
        return (int'(word[COL_MSB:COL_LSB]) < num_cols) &&
               (int'(word[FRM_MSB:FRM_LSB]) < frames_per_col);
    endfunction

endpackage

// File: rtl/fabric_frame_loader.sv
// Fabric frame loader: hunts the flash word stream for the sync word, then
// alternates between frame address words and NUM_ROWS data words, assembling
// each frame and pulsing a one-hot strobe for the addressed column/frame.
// Out-of-range addresses flag an error and their data is skipped; a falling
// edge of the reader busy flag mid-stream aborts the load.
module fabric_frame_loader
    import fabric_config_pkg::*;
#(
    parameter int NUM_COLUMNS    = 10,
    parameter int NUM_ROWS       = 8,
    parameter int FRAMES_PER_COL = 20
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [31:0]                           word_i,
    input  logic                                  word_valid_i,
    input  logic                                  reader_busy_i,
    output logic [NUM_ROWS*32-1:0]                frame_data_o,
    output logic [NUM_COLUMNS*FRAMES_PER_COL-1:0] frame_strobe_o,
    output logic                                  active_o,
    output logic                                  done_o,
    output logic                                  error_o,
    output logic [15:0]                           frames_written_o
);

    localparam int STRB_W = NUM_COLUMNS * FRAMES_PER_COL;
    localparam int IDX_W  = (STRB_W > 1) ? $clog2(STRB_W) : 1;
    localparam int RC_W   = $clog2(NUM_ROWS + 1);

    state_t                 state_q;
    logic [COL_W-1:0]       col_q;
    logic [FRM_W-1:0]       frm_q;
    logic [RC_W-1:0]        row_cnt_q;
    logic [NUM_ROWS*32-1:0] frame_data_q;
    logic                   strb_pend_q;
    logic [IDX_W-1:0]       strb_idx_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic [15:0]            frames_q;

    logic                   busy_fall_s;
    logic                   desync_hit_s;
    logic                   last_row_s;
    logic [STRB_W-1:0]      strobe_s;

    assign busy_fall_s  = busy_q & ~reader_busy_i;
    // A desync word arriving alongside the busy fall is a clean end of stream.
    assign desync_hit_s = word_valid_i && (state_q == S_ADDR) && (word_i == DESYNC_WORD);
    assign last_row_s   = (row_cnt_q == RC_W'(NUM_ROWS - 1));

    // Loader FSM with frame assembly, strobe queueing and status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            frm_q        <= '0;
            row_cnt_q    <= '0;
            frame_data_q <= '0;
            strb_pend_q  <= 1'b0;
            strb_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            frames_q     <= 16'h0000;
        end else begin
            busy_q      <= reader_busy_i;
            done_q      <= 1'b0;
            strb_pend_q <= 1'b0;
            if (busy_fall_s && (state_q != S_IDLE) && !desync_hit_s) begin
                state_q <= S_IDLE;
                error_q <= 1'b1;
            end else if (word_valid_i) begin
                case (state_q)
                    S_IDLE: begin
                        if (word_i == SYNC_WORD) begin
                            state_q  <= S_ADDR;
                            error_q  <= 1'b0;
                            frames_q <= 16'h0000;
                        end
                    end
                    S_ADDR: begin
                        if (word_i == DESYNC_WORD) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            col_q     <= word_i[COL_MSB:COL_LSB];
                            frm_q     <= word_i[FRM_MSB:FRM_LSB];
                            row_cnt_q <= '0;
                            if (addr_in_range(word_i, NUM_COLUMNS, FRAMES_PER_COL)) begin
                                state_q <= S_DATA;
                            end else begin
                                state_q <= S_SKIP;
                                error_q <= 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        frame_data_q[(NUM_ROWS - 1 - int'(row_cnt_q)) * 32 +: 32] <= word_i;
                        if (last_row_s) begin
                            state_q     <= S_ADDR;
                            strb_pend_q <= 1'b1;
                            strb_idx_q  <= IDX_W'(int'(col_q) * FRAMES_PER_COL + int'(frm_q));
                            if (frames_q != 16'hFFFF) begin
                                frames_q <= frames_q + 16'h0001;
                            end
                        end else begin
                            row_cnt_q <= row_cnt_q + RC_W'(1);
                        end
                    end
                    S_SKIP: begin
                        if (last_row_s) begin
                            state_q <= S_ADDR;
                        end else begin
                            row_cnt_q <= row_cnt_q + RC_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // One-hot decode of the queued strobe index.
    always_comb begin
        strobe_s = '0;
        if (strb_pend_q) begin
            strobe_s[strb_idx_q] = 1'b1;
        end else begin
            strobe_s = '0;
        end
    end

    assign frame_data_o     = frame_data_q;
    assign frame_strobe_o   = strobe_s;
    assign active_o         = (state_q != S_IDLE);
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign frames_written_o = frames_q;

endmodule

// File: tb/tb_fabric_frame_loader.sv
// Directed bench for fabric_frame_loader with a 4-column, 2-row, 4-frame fabric.
module tb_fabric_frame_loader;

    localparam int NC  = 4;
    localparam int NR  = 2;
    localparam int FPC = 4;

    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [31:0]          word_i;
    logic                 word_valid_i;
    logic                 reader_busy_i;
    logic [NR*32-1:0]     frame_data_o;
    logic [NC*FPC-1:0]    frame_strobe_o;
    logic                 active_o;
    logic                 done_o;
    logic                 error_o;
    logic [15:0]          frames_written_o;

    int total = 0;
    int bad   = 0;

    fabric_frame_loader #(
        .NUM_COLUMNS   (NC),
        .NUM_ROWS      (NR),
        .FRAMES_PER_COL(FPC)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .word_i          (word_i),
        .word_valid_i    (word_valid_i),
        .reader_busy_i   (reader_busy_i),
        .frame_data_o    (frame_data_o),
        .frame_strobe_o  (frame_strobe_o),
        .active_o        (active_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .frames_written_o(frames_written_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one word for one clock, then drop valid; returns at the next falling edge.
    task automatic put(input logic [31:0] w);
        word_i       = w;
        word_valid_i = 1'b1;
        @(negedge clk_i);
        word_valid_i = 1'b0;
    endtask

    // Present one word for one clock and leave valid high for back-to-back use.
    task automatic put_bb(input logic [31:0] w);
        word_i       = w;
        word_valid_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni        = 1'b0;
        word_i        = 32'h0000_0000;
        word_valid_i  = 1'b0;
        reader_busy_i = 1'b1;
        repeat (3) step();
        chk("rst_data",   64'(frame_data_o), 64'h0);
        chk("rst_strobe", 64'(frame_strobe_o), 64'h0);
        chk("rst_active", 64'(active_o), 64'h0);
        chk("rst_done",   64'(done_o), 64'h0);
        chk("rst_error",  64'(error_o), 64'h0);
        chk("rst_frames", 64'(frames_written_o), 64'h0);
        rst_ni = 1'b1;
        step();

        // 1. invalid address skipped with error, then a good frame col1/frm2
        put(SYNC);
        chk("t1_active", 64'(active_o), 64'h1);
        put(32'h0140_0000);
        chk("t1_err_badaddr", 64'(error_o), 64'h1);
        put(32'h1111_1111);
        chk("t1_skip_strb0", 64'(frame_strobe_o), 64'h0);
        put(32'h2222_2222);
        chk("t1_skip_strb1", 64'(frame_strobe_o), 64'h0);
        chk("t1_skip_data",  64'(frame_data_o), 64'h0);
        put(32'h0110_0000);
        put(32'hAAAA_AAAA);
        chk("t1_mid_strb", 64'(frame_strobe_o), 64'h0);
        put(32'h5555_5555);
        chk("t1_data",   64'(frame_data_o), 64'hAAAA_AAAA_5555_5555);
        chk("t1_strobe", 64'(frame_strobe_o), 64'h0040);
        chk("t1_frames", 64'(frames_written_o), 64'h1);
        step();
        chk("t1_strobe_off", 64'(frame_strobe_o), 64'h0);
        chk("t1_data_hold",  64'(frame_data_o), 64'hAAAA_AAAA_5555_5555);
        chk("t1_err_sticky", 64'(error_o), 64'h1);

        // 2. leave via desync, then words before a sync are ignored
        put(DESYNC);
        chk("t2_done_exit",   64'(done_o), 64'h1);
        chk("t2_active_exit", 64'(active_o), 64'h0);
        step();
        chk("t2_done_off", 64'(done_o), 64'h0);
        put(32'h1234_5678);
        chk("t2_hunt_active", 64'(active_o), 64'h0);
        put(DESYNC);
        chk("t2_hunt_done",   64'(done_o), 64'h0);
        chk("t2_hunt_active2", 64'(active_o), 64'h0);
        chk("t2_hunt_err",    64'(error_o), 64'h1);

        // 3. back-to-back words through two frames and a desync
        put_bb(SYNC);
        chk("t3_sync_err",    64'(error_o), 64'h0);
        chk("t3_sync_frames", 64'(frames_written_o), 64'h0);
        put_bb(32'h0318_0000);
        put_bb(32'hDEAD_BEEF);
        chk("t3_f1_mid", 64'(frame_strobe_o), 64'h0);
        put_bb(32'h0123_4567);
        chk("t3_f1_strobe", 64'(frame_strobe_o), 64'h8000);
        chk("t3_f1_data",   64'(frame_data_o), 64'hDEAD_BEEF_0123_4567);
        chk("t3_f1_frames", 64'(frames_written_o), 64'h1);
        put_bb(32'h0000_0000);
        chk("t3_f1_strb_off", 64'(frame_strobe_o), 64'h0);
        put_bb(32'hCAFE_F00D);
        chk("t3_f2_partial", 64'(frame_data_o), 64'hCAFE_F00D_0123_4567);
        put_bb(32'h8765_4321);
        chk("t3_f2_strobe", 64'(frame_strobe_o), 64'h0001);
        chk("t3_f2_data",   64'(frame_data_o), 64'hCAFE_F00D_8765_4321);
        chk("t3_f2_frames", 64'(frames_written_o), 64'h2);
        put_bb(DESYNC);
        word_valid_i = 1'b0;
        chk("t3_strb_off", 64'(frame_strobe_o), 64'h0);
        chk("t3_done",     64'(done_o), 64'h1);
        chk("t3_inactive", 64'(active_o), 64'h0);
        step();
        chk("t3_done_off", 64'(done_o), 64'h0);

        // 4. busy falls mid-frame
        put(SYNC);
        chk("t4_frames_clr", 64'(frames_written_o), 64'h0);
        put(32'h0208_0000);
        put(32'h1111_2222);
        chk("t4_partial", 64'(frame_data_o), 64'h1111_2222_8765_4321);
        reader_busy_i = 1'b0;
        step();
        chk("t4_abort_err",    64'(error_o), 64'h1);
        chk("t4_abort_active", 64'(active_o), 64'h0);
        chk("t4_abort_strb",   64'(frame_strobe_o), 64'h0);
        reader_busy_i = 1'b1;
        step();
        chk("t4_no_late_strb", 64'(frame_strobe_o), 64'h0);
        chk("t4_frames_abort", 64'(frames_written_o), 64'h0);
        put(SYNC);
        chk("t4_resync_err",    64'(error_o), 64'h0);
        chk("t4_resync_active", 64'(active_o), 64'h1);

        // 5. async reset in the middle of a frame
        put(32'h0008_0000);
        put(32'h9999_0000);
        put(32'h0000_9999);
        chk("t5_pre_strobe", 64'(frame_strobe_o), 64'h0002);
        chk("t5_pre_frames", 64'(frames_written_o), 64'h1);
        put(32'h0208_0000);
        put(32'h3333_4444);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t5_rst_data",   64'(frame_data_o), 64'h0);
        chk("t5_rst_active", 64'(active_o), 64'h0);
        chk("t5_rst_frames", 64'(frames_written_o), 64'h0);
        chk("t5_rst_strobe", 64'(frame_strobe_o), 64'h0);
        step();
        rst_ni = 1'b1;
        step();
        put(SYNC);
        put(32'h0110_0000);
        put(32'hAAAA_AAAA);
        put(32'h5555_5555);
        chk("t5_data",   64'(frame_data_o), 64'hAAAA_AAAA_5555_5555);
        chk("t5_strobe", 64'(frame_strobe_o), 64'h0040);
        chk("t5_frames", 64'(frames_written_o), 64'h1);

        // 6. desync and busy fall together
        word_i        = DESYNC;
        word_valid_i  = 1'b1;
        reader_busy_i = 1'b0;
        step();
        word_valid_i  = 1'b0;
        reader_busy_i = 1'b1;
        chk("t6_done",   64'(done_o), 64'h1);
        chk("t6_err",    64'(error_o), 64'h0);
        chk("t6_active", 64'(active_o), 64'h0);
        step();
        chk("t6_done_off", 64'(done_o), 64'h0);
        chk("t6_err_hold", 64'(error_o), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
